vrased_reset_ctrl: RTL and testbench
====================================

# vrased_reset_ctrl

Central reset sequencer for the VRASED hardware monitors. It collects violation flags from every monitor (memory-access, atomicity, DMA, counter-protection), selects a priority cause, and drives a single stretched reset to the MSP430 core. Reset is released only once the core fetches from the reset handler with no violation pending. The block owns the shared core-reset resource, so individual monitors no longer drive the core reset directly.

## Interface
- `NUM_SRC`, 4: number of violation sources (1..8).
- `HOLD_CYCLES`, 16: minimum cycles in HOLD (2..255).
- `RESET_HANDLER`, 16'hFFFE: PC value that qualifies release.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `viol` in NUM_SRC: per-monitor violation flags, level, sampled every edge; bit 0 is highest priority.
- `pc` in 16: core program counter.
- `clr_cause` in 1: single-cycle pulse; clears `cause`, `pending` and `cause_valid`, honoured in IDLE only.
- `reset` out 1: registered core reset, active high.
- `cause` out NUM_SRC: one-hot, first (priority-selected) source of the current or last event.
- `pending` out NUM_SRC: sticky OR of every `viol` bit seen since the last clear.
- `cause_valid` out 1: `cause` holds a captured event.
- `viol_count` out 8: number of IDLE→HOLD entries, saturating at 255.
- `busy` out 1: state ≠ IDLE.

## Operation
- The states are IDLE, HOLD and WAIT. The 8-bit down-counter `cnt` is used in HOLD only.
- While `rst_n` = 0 at an edge:
  - state ← IDLE; `reset`, `cause`, `pending`, `cause_valid`, `viol_count` and `cnt` ← 0.
  - This overrides every other condition, including mid-HOLD and mid-WAIT.
- IDLE, when `viol` ≠ 0:
  - `cause` ← lowest-index set bit; `cause_valid` ← 1; `pending` |= `viol`.
  - `viol_count` += 1 (saturating); `cnt` ← HOLD_CYCLES−1; `reset` ← 1; state ← HOLD.
  - The new `cause` overwrites any older uncleared cause.
- IDLE, when `viol` = 0 and `clr_cause` = 1: `cause`, `pending` and `cause_valid` ← 0.
  - If `viol` ≠ 0 in the same cycle as `clr_cause`, the violation wins and the clear is ignored.
- HOLD:
  - `reset` stays 1; `pending` |= `viol`; `cause` is frozen.
  - If `cnt` = 0, state ← WAIT; otherwise `cnt` −= 1.
  - Further violations neither extend HOLD nor bump `viol_count`.
- WAIT:
  - `reset` stays 1; `pending` |= `viol`.
  - If `viol` ≠ 0: `cnt` ← HOLD_CYCLES−1 and state ← HOLD. This re-entry does not increment `viol_count`.
  - Else if `pc` = RESET_HANDLER: `reset` ← 0 and state ← IDLE.
- `clr_cause` is ignored outside IDLE.
- `busy` is combinational from state. All other outputs are registered.

## Timing
- A violation sampled at edge k gives `reset` = 1, `busy` = 1, `cause_valid` = 1 and the updated `viol_count` from edge k onward.
- HOLD occupies exactly HOLD_CYCLES cycles; WAIT is entered at edge k+HOLD_CYCLES.
- Release:
  - The earliest release condition is sampled at edge k+HOLD_CYCLES+1 (the first WAIT edge).
  - `reset` = 0 after that edge, so the minimum reset pulse is HOLD_CYCLES+1 cycles.
- Release edge j (`pc` = RESET_HANDLER, `viol` = 0) → `reset` = 0 and state IDLE after edge j.
- A violation in IDLE on the cycle right after release starts a new event immediately; there is no dead cycle.
- `viol` held continuously: the block cycles HOLD→WAIT→HOLD and never releases; `viol_count` stays constant.
- `pc` = RESET_HANDLER during HOLD has no effect.

## Test plan
- Single event (HOLD_CYCLES=16): `viol` = 4'b0100 for 1 cycle, `pc` = 16'hFFFE throughout.
  - `reset` is high for exactly 17 cycles.
  - `cause` = 4'b0100, `pending` = 4'b0100, `viol_count` = 1, `busy` falls with `reset`.
- Priority: `viol` = 4'b1010 in one cycle → `cause` = 4'b0010, `pending` = 4'b1010.
  - Then `viol` = 4'b0001 during HOLD → `pending` = 4'b1011, `cause` unchanged, `viol_count` = 1.
- Handler gating: `pc` ≠ 16'hFFFE for 40 cycles after HOLD ends → `reset` stays 1.
  - `pc` = 16'hFFFE at edge j → `reset` = 0 after edge j.
- WAIT re-violation: in WAIT, `viol` = 4'b1000 together with `pc` = 16'hFFFE → no release.
  - The block re-enters HOLD; the next release comes no sooner than 17 cycles later; `viol_count` is unchanged.
- Saturation and clear:
  - 260 separate events → `viol_count` = 255.
  - `clr_cause` in IDLE → `cause`, `pending` and `cause_valid` = 0 after the edge; `viol_count` stays 255.
  - `clr_cause` during HOLD → no effect.
- Reset mid-operation: `rst_n` = 0 for 1 cycle during HOLD (cnt = 7).
  - Next cycle: state IDLE and all outputs = 0.
  - A following violation produces a full 17-cycle reset pulse.

Source files
------------

// File: rtl/vrased_reset_ctrl.sv
// Central reset sequencer for the VRASED monitors: latches a priority cause,
// stretches the core reset, and releases only on a clean fetch from the reset handler.
module vrased_reset_ctrl #(
    parameter int          NUM_SRC       = 4,
    parameter int          HOLD_CYCLES   = 16,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] viol,
    input  logic [15:0]        pc,
    input  logic               clr_cause,
    output logic               reset,
    output logic [NUM_SRC-1:0] cause,
    output logic [NUM_SRC-1:0] pending,
    output logic               cause_valid,
    output logic [7:0]         viol_count,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    localparam logic [7:0]         HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [NUM_SRC-1:0] ONE       = NUM_SRC'(1);

    state_t             state;
    logic [7:0]         cnt;
    logic [NUM_SRC-1:0] first;
    logic               any_viol;

    // Isolate the lowest-index set bit: bit 0 has the highest priority.
    assign first    = viol & (~viol + ONE);
    assign any_viol = |viol;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            reset       <= 1'b0;
            cause       <= '0;
            pending     <= '0;
            cause_valid <= 1'b0;
            viol_count  <= 8'd0;
            cnt         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_viol) begin
                        cause       <= first;
                        cause_valid <= 1'b1;
                        pending     <= pending | viol;
                        viol_count  <= (viol_count == 8'hFF) ? viol_count : viol_count + 8'd1;
                        cnt         <= HOLD_LOAD;
                        reset       <= 1'b1;
                        state       <= HOLD;
                    end else if (clr_cause) begin
                        cause       <= '0;
                        pending     <= '0;
                        cause_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    reset   <= 1'b1;
                    pending <= pending | viol;
                    if (cnt == 8'd0)
                        state <= WAIT;
                    else
                        cnt <= cnt - 8'd1;
                end
                WAIT: begin
                    reset   <= 1'b1;
                    pending <= pending | viol;
                    // A fresh violation restarts the hold window without counting a new event.
                    if (any_viol) begin
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                    end else if (pc == RESET_HANDLER) begin
                        reset <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed self-checking bench for vrased_reset_ctrl (NUM_SRC=4, HOLD_CYCLES=16).
module tb_vrased_reset_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  viol;
    logic [15:0] pc;
    logic        clr_cause;
    logic        reset;
    logic [3:0]  cause;
    logic [3:0]  pending;
    logic        cause_valid;
    logic [7:0]  viol_count;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    vrased_reset_ctrl #(.NUM_SRC(4), .HOLD_CYCLES(16), .RESET_HANDLER(16'hFFFE)) dut (
        .clk(clk), .rst_n(rst_n), .viol(viol), .pc(pc), .clr_cause(clr_cause),
        .reset(reset), .cause(cause), .pending(pending), .cause_valid(cause_valid),
        .viol_count(viol_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; viol = '0; pc = 16'h0000; clr_cause = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Apply a one-cycle violation pulse; returns after the sampling edge.
    task automatic pulse(input logic [3:0] v);
        viol = v;
        step();
        viol = '0;
    endtask

    // Counts further cycles with reset high until release; n includes the first cycle.
    task automatic wait_release(output int n);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (reset) n++;
            else return;
        end
        compared++; mismatched++;
        $display("FAIL release_timeout got reset=%b want 0 within 300 cycles", reset);
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        compared++;
        if ({reset, busy, cause, pending, cause_valid, viol_count} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_state got %h want 0", {reset, busy, cause, pending, cause_valid, viol_count});
        end
        n = 0;
    endtask

    task automatic test_single_event();
        int n;
        do_reset();
        pc = 16'hFFFE;
        pulse(4'b0100);
        compared++;
        if ({reset, busy, cause_valid, viol_count} !== {3'b111, 8'd1}) begin
            mismatched++;
            $display("FAIL single_entry got %b want %b", {reset, busy, cause_valid, viol_count}, {3'b111, 8'd1});
        end
        wait_release(n);
        compared++;
        if (n !== 17) begin mismatched++; $display("FAIL single_width got %0d want 17", n); end
        compared++;
        if ({busy, cause, pending, viol_count} !== {1'b0, 4'b0100, 4'b0100, 8'd1}) begin
            mismatched++;
            $display("FAIL single_after got %h want %h", {busy, cause, pending, viol_count}, {1'b0, 4'b0100, 4'b0100, 8'd1});
        end
    endtask

    task automatic test_priority();
        do_reset();
        pulse(4'b1010);
        compared++;
        if ({cause, pending} !== {4'b0010, 4'b1010}) begin
            mismatched++;
            $display("FAIL prio_cause got %b want %b", {cause, pending}, {4'b0010, 4'b1010});
        end
        step();
        pulse(4'b0001);
        compared++;
        if ({cause, pending, viol_count} !== {4'b0010, 4'b1011, 8'd1}) begin
            mismatched++;
            $display("FAIL prio_hold got %h want %h", {cause, pending, viol_count}, {4'b0010, 4'b1011, 8'd1});
        end
    endtask

    task automatic test_handler_gating();
        logic stayed;
        do_reset();
        pc = 16'h1234;
        pulse(4'b0100);
        for (int i = 0; i < 16; i++) step();
        stayed = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!reset || !busy) stayed = 1'b0;
        end
        compared++;
        if (stayed !== 1'b1) begin mismatched++; $display("FAIL gate_hold got %b want 1", stayed); end
        pc = 16'hFFFE;
        step();
        compared++;
        if ({reset, busy} !== 2'b00) begin mismatched++; $display("FAIL gate_release got %b want 00", {reset, busy}); end
    endtask

    task automatic test_wait_reviol();
        int n;
        do_reset();
        pc = 16'h0000;
        pulse(4'b0100);
        for (int i = 0; i < 16; i++) step();
        viol = 4'b1000; pc = 16'hFFFE;
        step();
        viol = '0;
        compared++;
        if ({reset, busy, viol_count} !== {2'b11, 8'd1}) begin
            mismatched++;
            $display("FAIL wait_noreleasae got %h want %h", {reset, busy, viol_count}, {2'b11, 8'd1});
        end
        wait_release(n);
        compared++;
        if (n !== 17) begin mismatched++; $display("FAIL wait_rehold got %0d want 17", n); end
        compared++;
        if ({pending, viol_count, cause} !== {4'b1100, 8'd1, 4'b0100}) begin
            mismatched++;
            $display("FAIL wait_state got %h want %h", {pending, viol_count, cause}, {4'b1100, 8'd1, 4'b0100});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        pc = 16'hFFFE;
        pulse(4'b0001);
        wait_release(n);
        pulse(4'b0010);
        compared++;
        if ({reset, busy, cause, viol_count} !== {2'b11, 4'b0010, 8'd2}) begin
            mismatched++;
            $display("FAIL b2b_restart got %h want %h", {reset, busy, cause, viol_count}, {2'b11, 4'b0010, 8'd2});
        end
    endtask

    task automatic test_saturation_clear();
        int n;
        do_reset();
        pc = 16'hFFFE;
        for (int e = 0; e < 260; e++) begin
            pulse(4'b0001);
            wait_release(n);
        end
        compared++;
        if (viol_count !== 8'd255) begin mismatched++; $display("FAIL sat_count got %0d want 255", viol_count); end
        pulse(4'b0100);
        clr_cause = 1'b1;
        step();
        clr_cause = 1'b0;
        compared++;
        if ({cause_valid, cause, pending} !== {1'b1, 4'b0100, 4'b0101}) begin
            mismatched++;
            $display("FAIL clr_in_hold got %b want %b", {cause_valid, cause, pending}, {1'b1, 4'b0100, 4'b0101});
        end
        wait_release(n);
        clr_cause = 1'b1;
        step();
        clr_cause = 1'b0;
        compared++;
        if ({cause_valid, cause, pending, viol_count} !== {9'd0, 8'd255}) begin
            mismatched++;
            $display("FAIL clr_idle got %h want %h", {cause_valid, cause, pending, viol_count}, {9'd0, 8'd255});
        end
        viol = 4'b0010; clr_cause = 1'b1;
        step();
        viol = '0; clr_cause = 1'b0;
        compared++;
        if ({cause_valid, cause, pending} !== {1'b1, 4'b0010, 4'b0010}) begin
            mismatched++;
            $display("FAIL clr_vs_viol got %b want %b", {cause_valid, cause, pending}, {1'b1, 4'b0010, 4'b0010});
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        do_reset();
        pc = 16'hFFFE;
        pulse(4'b1000);
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        compared++;
        if ({reset, busy, cause, pending, cause_valid, viol_count} !== 19'd0) begin
            mismatched++;
            $display("FAIL midrst_state got %h want 0", {reset, busy, cause, pending, cause_valid, viol_count});
        end
        pulse(4'b0001);
        wait_release(n);
        compared++;
        if (n !== 17) begin mismatched++; $display("FAIL midrst_width got %0d want 17", n); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_priority();
        test_handler_gating();
        test_wait_reviol();
        test_back_to_back();
        test_saturation_clear();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
